// File: rtl/cnn_core_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cnn_core_mac_pipe
// Purpose  : Pipelined multi-lane signed multiply-accumulate. Each accepted
//            beat multiplies LANES activation/weight pairs in full precision.
//            The products pass through NUM_STAGE registers and are reduced
//            into one registered lane sum. The sum is then accumulated across
//            a frame bounded by first/last flags, with optional saturation.
//            A single global stall derived from the output handshake freezes
//            the whole pipeline. There is no skid buffer.
// Ports    : ap_clk, ap_rst        - clock, asynchronous active-high reset
//            in_valid/in_ready     - input beat handshake
//            in_data0              - LANES x DIN0_WIDTH signed activations
//            in_data1              - LANES x DIN1_WIDTH signed weights
//            in_first/in_last      - frame delimiters
//            out_valid/out_ready   - result handshake
//            out_data              - ACC_WIDTH signed frame result
//            out_sat               - frame saw at least one clamp
// Revision : 1.0 - initial release
// ============================================================================
module cnn_core_mac_pipe #(
  parameter int DIN0_WIDTH = 12,
  parameter int DIN1_WIDTH = 7,
  parameter int LANES      = 4,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_WIDTH  = 32,
  parameter int SATURATE   = 1
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DIN0_WIDTH-1:0] in_data0,
  input  logic [LANES*DIN1_WIDTH-1:0] in_data1,
  input  logic                        in_first,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_WIDTH-1:0]        out_data,
  output logic                        out_sat
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
  localparam int SUM_WIDTH  = PROD_WIDTH + $clog2(LANES);
  // Wide enough that base + sum can never overflow before clamping.
  localparam int EXT_WIDTH  = ACC_WIDTH + SUM_WIDTH;

  localparam logic signed [EXT_WIDTH-1:0] ACC_MAX =
    {{(SUM_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic signed [EXT_WIDTH-1:0] ACC_MIN =
    {{(SUM_WIDTH + 1){1'b1}}, {(ACC_WIDTH - 1){1'b0}}};

  // Global stall: nothing moves while a result waits unconsumed.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // --------------------------------------------------------------------------
  // Lane multipliers (full precision, no truncation)
  // --------------------------------------------------------------------------
  logic signed [PROD_WIDTH-1:0] prod_in [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DIN0_WIDTH-1:0] act;
    logic signed [DIN1_WIDTH-1:0] wgt;
    assign act        = in_data0[i*DIN0_WIDTH +: DIN0_WIDTH];
    assign wgt        = in_data1[i*DIN1_WIDTH +: DIN1_WIDTH];
    assign prod_in[i] = PROD_WIDTH'(act) * PROD_WIDTH'(wgt);
  end

  // --------------------------------------------------------------------------
  // Multiply pipeline: stage 0 captures the products of the accepted beat.
  // Later stages are plain delay registers that carry the frame flags along.
  // --------------------------------------------------------------------------
  logic signed [PROD_WIDTH-1:0] prod_q [NUM_STAGE][LANES];
  logic [NUM_STAGE-1:0]         stg_valid;
  logic [NUM_STAGE-1:0]         stg_first;
  logic [NUM_STAGE-1:0]         stg_last;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stg_valid <= '0;
      stg_first <= '0;
      stg_last  <= '0;
      for (int s = 0; s < NUM_STAGE; s++) begin
        for (int l = 0; l < LANES; l++) begin
          prod_q[s][l] <= '0;
        end
      end
    end else if (advance) begin
      stg_valid[0] <= in_valid;
      stg_first[0] <= in_first;
      stg_last[0]  <= in_last;
      for (int l = 0; l < LANES; l++) begin
        prod_q[0][l] <= prod_in[l];
      end
      for (int s = 1; s < NUM_STAGE; s++) begin
        stg_valid[s] <= stg_valid[s-1];
        stg_first[s] <= stg_first[s-1];
        stg_last[s]  <= stg_last[s-1];
        for (int l = 0; l < LANES; l++) begin
          prod_q[s][l] <= prod_q[s-1][l];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lane reduction: exact sum of sign-extended products, then one register.
  // --------------------------------------------------------------------------
  logic signed [SUM_WIDTH-1:0] sum_comb;
  logic signed [SUM_WIDTH-1:0] sum_q;
  logic                        sum_valid;
  logic                        sum_first;
  logic                        sum_last;

  always_comb begin
    sum_comb = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_comb = sum_comb + SUM_WIDTH'(prod_q[NUM_STAGE-1][l]);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      sum_q     <= '0;
      sum_valid <= 1'b0;
      sum_first <= 1'b0;
      sum_last  <= 1'b0;
    end else if (advance) begin
      sum_q     <= sum_comb;
      sum_valid <= stg_valid[NUM_STAGE-1];
      sum_first <= stg_first[NUM_STAGE-1];
      sum_last  <= stg_last[NUM_STAGE-1];
    end
  end

  // --------------------------------------------------------------------------
  // Accumulate stage
  // --------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        sticky;
  logic signed [EXT_WIDTH-1:0] base_ext;
  logic signed [EXT_WIDTH-1:0] next_ext;
  logic signed [ACC_WIDTH-1:0] next_acc;
  logic                        clamp;
  logic                        sticky_next;

  always_comb begin
    base_ext = EXT_WIDTH'(acc);
    if (sum_first) begin
      base_ext = '0;
    end
    next_ext = base_ext + EXT_WIDTH'(sum_q);
    // Without saturation the low bits are exactly the wrapped result.
    next_acc = next_ext[ACC_WIDTH-1:0];
    clamp    = 1'b0;
    if (SATURATE != 0) begin
      if (next_ext > ACC_MAX) begin
        next_acc = ACC_MAX[ACC_WIDTH-1:0];
        clamp    = 1'b1;
      end else if (next_ext < ACC_MIN) begin
        next_acc = ACC_MIN[ACC_WIDTH-1:0];
        clamp    = 1'b1;
      end
    end
    // A frame start restarts the sticky flag from this beat's own clamp.
    sticky_next = clamp | (sticky & !sum_first);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (advance) begin
      // advance implies any held result is consumed now, so valid either
      // reloads from a last beat or drops.
      out_valid <= sum_valid && sum_last;
      if (sum_valid) begin
        acc    <= next_acc;
        sticky <= sticky_next;
        if (sum_last) begin
          out_data <= next_acc;
          out_sat  <= sticky_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_core_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_core_mac_pipe
// Purpose  : Self-checking bench for cnn_core_mac_pipe. Three instances share
//            one stimulus: default (32-bit, saturating), 20-bit saturating and
//            20-bit wrapping. A table of single-beat frames is checked against
//            constants. Hand-written sequences cover multi-beat frames, stall
//            and reset. Random traffic is checked against an arithmetic
//            frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_core_mac_pipe;

  localparam int LANES = 4;
  localparam int W0    = 12;
  localparam int W1    = 7;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_first;
  logic                  in_last;
  logic                  out_ready;
  logic [LANES*W0-1:0]   din0;
  logic [LANES*W1-1:0]   din1;

  logic                  ir0, ir1, ir2;
  logic                  ov0, ov1, ov2;
  logic [31:0]           od0;
  logic [19:0]           od1, od2;
  logic                  os0, os1, os2;

  always #5 clk = ~clk;

  cnn_core_mac_pipe u_dut (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .in_data0(din0), .in_data1(din1), .in_first(in_first), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sat(os0));

  cnn_core_mac_pipe #(.ACC_WIDTH(20), .SATURATE(1)) u_sat20 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .in_data0(din0), .in_data1(din1), .in_first(in_first), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sat(os1));

  cnn_core_mac_pipe #(.ACC_WIDTH(20), .SATURATE(0)) u_wrap20 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .in_data0(din0), .in_data1(din1), .in_first(in_first), .in_last(in_last),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_sat(os2));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: frame arithmetic per configuration, results queued in
  // acceptance order.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [2:0][63:0] d;
    logic [2:0]       s;
  } exp_t;

  exp_t   exp_q[$];
  longint m_acc [3];
  bit     m_sticky [3];
  int     cw [3] = '{32, 20, 20};
  bit     cs [3] = '{1'b1, 1'b1, 1'b0};

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_acc[c]    = 0;
      m_sticky[c] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic model_accept();
    longint sum, base, nxt, lim;
    bit     clamp;
    exp_t   e;
    sum = 0;
    for (int i = 0; i < LANES; i++) begin
      sum += longint'($signed(din0[i*W0 +: W0])) * longint'($signed(din1[i*W1 +: W1]));
    end
    for (int c = 0; c < 3; c++) begin
      base  = in_first ? 0 : m_acc[c];
      nxt   = base + sum;
      clamp = 1'b0;
      lim   = longint'(1) <<< (cw[c] - 1);
      if (cs[c]) begin
        if (nxt > lim - 1) begin
          nxt = lim - 1;  clamp = 1'b1;
        end else if (nxt < -lim) begin
          nxt = -lim;     clamp = 1'b1;
        end
      end else begin
        nxt = ((nxt % (2 * lim)) + 2 * lim) % (2 * lim);
        if (nxt >= lim) nxt -= 2 * lim;
      end
      m_sticky[c] = clamp | (in_first ? 1'b0 : m_sticky[c]);
      m_acc[c]    = nxt;
      e.d[c]      = nxt;
      e.s[c]      = m_sticky[c];
    end
    if (in_last) exp_q.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL unexpected_result: got %0d, expected no result", $signed(od0));
      return;
    end
    e = exp_q.pop_front();
    chk("res_data_a32",  64'($signed(od0)), e.d[0]);
    chk("res_sat_a32",   64'(os0), 64'(e.s[0]));
    chk("res_data_s20",  64'($signed(od1)), e.d[1]);
    chk("res_sat_s20",   64'(os1), 64'(e.s[1]));
    chk("res_data_w20",  64'($signed(od2)), e.d[2]);
    chk("res_sat_w20",   64'(os2), 64'(e.s[2]));
    chk("res_valid_cfg", 64'({ov1, ov2}), 64'(2'b11));
    chk("res_ready_cfg", 64'({ir1, ir2}), 64'({ir0, ir0}));
  endtask

  // Values sampled in the most recent cycle.
  logic        s_acc, s_ov, s_ir, s_os0, s_os1, s_os2;
  logic [31:0] s_od0;
  logic [19:0] s_od1, s_od2;

  // Called at negedge+1 with inputs already set; samples well before the
  // next rising edge, then returns at the following negedge+1.
  task automatic clk_step();
    #1;
    s_acc = in_valid && ir0;
    s_ov  = ov0;
    s_ir  = ir0;
    s_od0 = od0; s_od1 = od1; s_od2 = od2;
    s_os0 = os0; s_os1 = os1; s_os2 = os2;
    if (s_acc) model_accept();
    if (ov0 && out_ready) score();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic l);
    in_valid = v;
    in_first = f;
    in_last  = l;
  endtask

  function automatic logic [LANES*W0-1:0] lanes0(input int l0, input int l1, input int l2, input int l3);
    return {W0'(l3), W0'(l2), W0'(l1), W0'(l0)};
  endfunction

  function automatic logic [LANES*W1-1:0] lanes1(input int l0, input int l1, input int l2, input int l3);
    return {W1'(l3), W1'(l2), W1'(l1), W1'(l0)};
  endfunction

  // Waits for a result with a cycle budget; returns edges since acceptance.
  task automatic wait_result(input string name, output int lat);
    lat = 0;
    drive(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      clk_step();
      lat++;
      if (s_ov) break;
    end
    if (!s_ov) chk({name, "_timeout"}, 64'(s_ov), 64'(1));
  endtask

  typedef struct {
    logic [LANES*W0-1:0] a;
    logic [LANES*W1-1:0] b;
    longint              e32;
    longint              esat;
    bit                  esf;
    longint              ewrap;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int lat;
    int got;
    int k;
    logic        prev_stalled;
    logic [31:0] prev_d;

    // Single-beat frame table: {din0, din1, acc32, sat20, sat20 flag, wrap20}
    tbl[0] = '{lanes0(100, -200, 2047, -2048), lanes1(3, 5, -64, 63), -260732, -260732, 1'b0, -260732};
    tbl[1] = '{lanes0(-2048, -2048, -2048, -2048), lanes1(-64, -64, -64, -64), 524288, 524287, 1'b1, -524288};
    tbl[2] = '{lanes0(1, 1, 1, 1), lanes1(1, 1, 1, 1), 4, 4, 1'b0, 4};
    tbl[3] = '{lanes0(2047, 2047, 2047, 2047), lanes1(-64, -64, -64, -64), -524032, -524032, 1'b0, -524032};
    tbl[4] = '{lanes0(-2048, -2048, -2048, -2048), lanes1(63, 63, 63, 63), -516096, -516096, 1'b0, -516096};
    tbl[5] = '{lanes0(0, -1, 0, 0), lanes1(0, -1, 0, 0), 1, 1, 1'b0, 1};

    rst = 1'b1;
    out_ready = 1'b1;
    din0 = '0;
    din1 = '0;
    drive(1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(ov0), 64'(0));
    chk("reset_out_data",  64'(od0), 64'(0));
    chk("reset_out_sat",   64'(os0), 64'(0));
    rst = 1'b0;
    #1;
    chk("reset_in_ready",  64'(ir0), 64'(1));

    // ---------------- table-driven single-beat frames ----------------
    for (int i = 0; i < 6; i++) begin
      din0 = tbl[i].a;
      din1 = tbl[i].b;
      drive(1'b1, 1'b1, 1'b1);
      clk_step();
      chk("tbl_accept", 64'(s_acc), 64'(1));
      wait_result("tbl", lat);
      chk("tbl_latency",   64'(lat), 64'(4));
      chk("tbl_data_a32",  64'($signed(s_od0)), 64'(tbl[i].e32));
      chk("tbl_sat_a32",   64'(s_os0), 64'(0));
      chk("tbl_data_s20",  64'($signed(s_od1)), 64'(tbl[i].esat));
      chk("tbl_sat_s20",   64'(s_os1), 64'(tbl[i].esf));
      chk("tbl_data_w20",  64'($signed(s_od2)), 64'(tbl[i].ewrap));
      chk("tbl_sat_w20",   64'(s_os2), 64'(0));
    end

    // ---------------- 3-beat frame, back to back ----------------
    din0 = lanes0(1, 1, 1, 1);
    din1 = lanes1(1, 1, 1, 1);
    drive(1'b1, 1'b1, 1'b0);
    clk_step();
    chk("mb_ov_beat0", 64'(s_ov), 64'(0));
    drive(1'b1, 1'b0, 1'b0);
    clk_step();
    chk("mb_ov_beat1", 64'(s_ov), 64'(0));
    drive(1'b1, 1'b0, 1'b1);
    clk_step();
    chk("mb_ov_beat2", 64'(s_ov), 64'(0));
    wait_result("mb", lat);
    chk("mb_latency", 64'(lat), 64'(4));
    chk("mb_data",    64'($signed(s_od0)), 64'(12));
    clk_step();
    chk("mb_single_result", 64'(s_ov), 64'(0));

    // ---------------- stall: five frames, out_ready low 6 cycles ----------------
    k = 0;
    got = 0;
    prev_stalled = 1'b0;
    prev_d = '0;
    din1 = lanes1(1, 0, 0, 0);
    for (int c = 0; c < 80 && got < 5; c++) begin
      out_ready = (c >= 6);
      if (k < 5) begin
        din0 = lanes0(k + 1, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b1);
      end else begin
        drive(1'b0, 1'b0, 1'b0);
      end
      clk_step();
      if (s_acc) k++;
      if (s_ov && !out_ready) begin
        chk("stall_in_ready", 64'(s_ir), 64'(0));
        if (prev_stalled) chk("stall_hold", 64'(s_od0), 64'(prev_d));
      end
      prev_stalled = s_ov && !out_ready;
      prev_d = s_od0;
      if (s_ov && out_ready) begin
        got++;
        chk("stall_order", 64'($signed(s_od0)), 64'(got));
      end
    end
    chk("stall_count", 64'(got), 64'(5));
    out_ready = 1'b1;

    // ---------------- reset mid-frame ----------------
    for (int v = 0; v < 2; v++) begin
      din0 = lanes0(1, 1, 1, 1);
      din1 = lanes1(1, 1, 1, 1);
      drive(1'b1, 1'b1, 1'b0);
      clk_step();
      drive(1'b1, 1'b0, 1'b0);
      clk_step();
      drive(1'b0, 1'b0, 1'b0);
      // v=1 lets the partial sum reach the accumulator before reset
      if (v == 1) repeat (5) clk_step();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 64'(ov0), 64'(0));
      chk("rst_out_data",  64'(od0), 64'(0));
      chk("rst_out_sat",   64'(os1), 64'(0));
      model_reset();
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(ir0), 64'(1));
      din0 = lanes0(7, 0, 0, 0);
      din1 = lanes1(1, 0, 0, 0);
      // v=1 sends a continuation beat: acc must have been cleared to 0
      drive(1'b1, (v == 0), 1'b1);
      clk_step();
      drive(1'b0, 1'b0, 1'b0);
      got = 0;
      for (int c = 0; c < 12; c++) begin
        clk_step();
        if (s_ov) begin
          got++;
          chk("rst_data", 64'($signed(s_od0)), 64'(7));
        end
      end
      chk("rst_result_count", 64'(got), 64'(1));
    end

    // ---------------- randomized traffic vs model ----------------
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        din0 = lanes0(-2048, -2048, -2048, -2048);
        din1 = ($urandom_range(0, 1) == 0) ? lanes1(-64, -64, -64, -64) : lanes1(63, 63, 63, 63);
      end else begin
        din0 = (LANES*W0)'({$urandom(), $urandom()});
        din1 = (LANES*W1)'($urandom());
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clk_step();
    end

    // drain
    drive(1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) clk_step();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
